fpu_top: RTL and testbench

FPU_TOP -- requirements
Module: fpu_top

---
 rtl/fpu_pkg.sv | 55 +++++
 rtl/fpu_div.sv | 44 ++++
 rtl/fpu_top.sv | 234 +++++++++++++++++++++++
 tb/tb_fpu_top.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared types, constants and unpack helpers for the binary32 FPU
package fpu_pkg;

  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3} op_t;

  typedef enum logic [2:0] {IDLE, UNPACK, EXEC, ROUND, DONE} state_t;

  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;

  // exp is a biased exponent held as 10-bit two's complement so normalised
  // subnormals can go below 1; sig always has its leading one at bit 23.
  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [23:0] sig;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } ufloat_t;

  function automatic logic [4:0] f_clz27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && v[i]) begin
        n = 5'(26 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic logic [23:0] f_norm_sig(input logic [31:0] x);
    if (x[30:23] != 8'd0) return {1'b1, x[22:0]};
    return {1'b0, x[22:0]} << f_clz27({1'b0, x[22:0], 3'b000});
  endfunction

  function automatic ufloat_t f_unpack(input logic [31:0] x);
    ufloat_t u;
    u = '0;
    u.sign    = x[31];
    u.sig     = f_norm_sig(x);
    u.is_nan  = (x[30:23] == 8'hFF) && (x[22:0] != '0);
    u.is_inf  = (x[30:23] == 8'hFF) && (x[22:0] == '0);
    u.is_zero = (x[30:0] == '0);
    if (x[30:23] != 8'd0) u.exp = {2'b00, x[30:23]};
    else                  u.exp = 10'd1 - {5'd0, f_clz27({1'b0, x[22:0], 3'b000})};
    return u;
  endfunction

endpackage

// File: rtl/fpu_div.sv
// rtl/fpu_div.sv - restoring radix-2 significand divider, 26 quotient bits (built with FPU_DIV_EN)
module fpu_div (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [24:0] dividend,
  input  logic [23:0] divisor,
  output logic        done,
  output logic [25:0] quot,
  output logic        rem_nz
);

  logic [24:0] rem;
  logic [23:0] dvs;
  logic [4:0]  cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem  <= '0;
      dvs  <= '0;
      quot <= '0;
      cnt  <= '0;
    end else if (start) begin
      rem  <= dividend;
      dvs  <= divisor;
      quot <= '0;
      cnt  <= 5'd26;
    end else if (cnt != 5'd0) begin
      // remainder stays below the divisor, so the shift never drops a set bit
      if (rem >= {1'b0, dvs}) begin
        rem  <= (rem - {1'b0, dvs}) << 1;
        quot <= {quot[24:0], 1'b1};
      end else begin
        rem  <= rem << 1;
        quot <= {quot[24:0], 1'b0};
      end
      cnt <= cnt - 5'd1;
    end
  end

  assign done   = (cnt == 5'd1);
  assign rem_nz = (rem != '0);

endmodule

// File: rtl/fpu_top.sv
// rtl/fpu_top.sv - multicycle binary32 add/sub/mul/div with RNE rounding; divider built only with FPU_DIV_EN
module fpu_top
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        valid,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic [1:0]  op_sel,
  output logic [31:0] result,
  output logic        ready
);

  localparam logic signed [9:0] BIAS = 10'(EXP_BIAS);

  state_t state, state_nx;
  op_t    op_r;
  logic [31:0] a_raw, b_raw;
  ufloat_t ua, ub;
  logic exec_done;

  logic        ex_special, ex_sign, pr_special, pr_sign;
  logic [31:0] ex_val, pr_val, rnd_res;
  logic signed [9:0] ex_exp, pr_exp, ea, eb, big_e, sml_e, d, r_exp;
  logic [26:0] ex_sig, pr_sig, big27, small27, diff27, r_sig;
  logic        sb_eff, sx, a_big, big_s, sml_s, round_up;
  logic [23:0] big_m, sml_m;
  logic [4:0]  sh, lz;
  logic [50:0] aligned;
  logic [27:0] s28;
  logic [47:0] prod;
  logic [24:0] r_sum;
  logic [22:0] r_frac;

`ifdef FPU_DIV_EN
  logic        div_done, div_rem_nz, ex_use_div, pr_use_div;
  logic [25:0] div_q;
  logic [23:0] na, nb;

  assign na = f_norm_sig(a_raw);
  assign nb = f_norm_sig(b_raw);

  // dividend pre-shifted when sig A < sig B so the quotient always lands in [1,2)
  fpu_div u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (state == UNPACK && op_r == OP_DIV),
    .dividend ((na < nb) ? {na, 1'b0} : {1'b0, na}),
    .divisor  (nb),
    .done     (div_done),
    .quot     (div_q),
    .rem_nz   (div_rem_nz)
  );
  assign exec_done = (op_r != OP_DIV) || div_done;
`else
  assign exec_done = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      op_r       <= OP_ADD;
      a_raw      <= '0;
      b_raw      <= '0;
      ua         <= '0;
      ub         <= '0;
      pr_special <= 1'b0;
      pr_val     <= '0;
      pr_sign    <= 1'b0;
      pr_exp     <= '0;
      pr_sig     <= '0;
`ifdef FPU_DIV_EN
      pr_use_div <= 1'b0;
`endif
      result     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && valid) begin
        a_raw <= din1;
        b_raw <= din2;
        op_r  <= op_t'(op_sel);
      end
      if (state == UNPACK) begin
        ua <= f_unpack(a_raw);
        ub <= f_unpack(b_raw);
      end
      if (state == EXEC && exec_done) begin
        pr_special <= ex_special;
        pr_val     <= ex_val;
        pr_sign    <= ex_sign;
        pr_exp     <= ex_exp;
        pr_sig     <= ex_sig;
`ifdef FPU_DIV_EN
        pr_use_div <= ex_use_div;
`endif
      end
      if (state == ROUND) result <= rnd_res;
    end
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      IDLE:    if (valid) state_nx = UNPACK;
      UNPACK:  state_nx = EXEC;
      EXEC:    if (exec_done) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE: begin
        ready    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // EXEC datapath: produces sign, exponent and a 27-bit significand (24 + G/R/S)
  always_comb begin
    ex_special = 1'b0;
    ex_val     = '0;
    ex_sign    = 1'b0;
    ex_exp     = '0;
    ex_sig     = '0;
`ifdef FPU_DIV_EN
    ex_use_div = 1'b0;
`endif
    ea      = $signed(ua.exp);
    eb      = $signed(ub.exp);
    sx      = ua.sign ^ ub.sign;
    sb_eff  = ub.sign ^ (op_r == OP_SUB);
    a_big   = (ea > eb) || ((ea == eb) && (ua.sig >= ub.sig));
    big_s   = a_big ? ua.sign : sb_eff;
    sml_s   = a_big ? sb_eff : ua.sign;
    big_e   = a_big ? ea : eb;
    sml_e   = a_big ? eb : ea;
    big_m   = a_big ? ua.sig : ub.sig;
    sml_m   = a_big ? ub.sig : ua.sig;
    d       = big_e - sml_e;
    sh      = (d > 10'sd27) ? 5'd27 : d[4:0];
    aligned = {sml_m, 27'b0} >> sh;
    small27 = {aligned[50:25], aligned[24] | (|aligned[23:0])};
    big27   = {big_m, 3'b000};
    s28     = {1'b0, big27} + {1'b0, small27};
    diff27  = big27 - small27;
    lz      = f_clz27(diff27);
    prod    = {24'b0, ua.sig} * {24'b0, ub.sig};
    case (op_r)
      OP_ADD, OP_SUB: begin
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && (ua.sign != sb_eff))) begin
          ex_special = 1'b1; ex_val = QNAN;
        end else if (ua.is_inf) begin
          ex_special = 1'b1; ex_val = {ua.sign, POS_INF[30:0]};
        end else if (ub.is_inf) begin
          ex_special = 1'b1; ex_val = {sb_eff, POS_INF[30:0]};
        end else if (ua.is_zero && ub.is_zero) begin
          ex_special = 1'b1; ex_val = {ua.sign & sb_eff, 31'b0};
        end else if (ua.is_zero || ub.is_zero) begin
          ex_sign = ua.is_zero ? sb_eff : ua.sign;
          ex_exp  = ua.is_zero ? eb : ea;
          ex_sig  = {ua.is_zero ? ub.sig : ua.sig, 3'b000};
        end else if (big_s == sml_s) begin
          ex_sign = big_s;
          if (s28[27]) begin
            ex_exp = big_e + 10'sd1;
            ex_sig = {s28[27:2], s28[1] | s28[0]};
          end else begin
            ex_exp = big_e;
            ex_sig = s28[26:0];
          end
        end else if (diff27 == '0) begin
          ex_special = 1'b1; ex_val = '0;
        end else begin
          ex_sign = big_s;
          ex_exp  = big_e - $signed({5'd0, lz});
          ex_sig  = diff27 << lz;
        end
      end
      OP_MUL: begin
        if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf)) begin
          ex_special = 1'b1; ex_val = QNAN;
        end else if (ua.is_inf || ub.is_inf) begin
          ex_special = 1'b1; ex_val = {sx, POS_INF[30:0]};
        end else if (ua.is_zero || ub.is_zero) begin
          ex_special = 1'b1; ex_val = {sx, 31'b0};
        end else begin
          ex_sign = sx;
          if (prod[47]) begin
            ex_exp = ea + eb - BIAS + 10'sd1;
            ex_sig = {prod[47:22], |prod[21:0]};
          end else begin
            ex_exp = ea + eb - BIAS;
            ex_sig = {prod[46:21], |prod[20:0]};
          end
        end
      end
      default: begin
`ifdef FPU_DIV_EN
        if (ua.is_nan || ub.is_nan || (ua.is_zero && ub.is_zero) || (ua.is_inf && ub.is_inf)) begin
          ex_special = 1'b1; ex_val = QNAN;
        end else if (ua.is_inf || ub.is_zero) begin
          ex_special = 1'b1; ex_val = {sx, POS_INF[30:0]};
        end else if (ua.is_zero || ub.is_inf) begin
          ex_special = 1'b1; ex_val = {sx, 31'b0};
        end else begin
          ex_use_div = 1'b1;
          ex_sign    = sx;
          ex_exp     = ea - eb + BIAS - ((ua.sig < ub.sig) ? 10'sd1 : 10'sd0);
        end
`else
        ex_special = 1'b1;
        ex_val     = QNAN;
`endif
      end
    endcase
  end

  // round to nearest even, then overflow to infinity / flush below min normal
  always_comb begin
    r_sig = pr_sig;
`ifdef FPU_DIV_EN
    if (pr_use_div) r_sig = {div_q, div_rem_nz};
`endif
    round_up = r_sig[2] & (r_sig[3] | r_sig[1] | r_sig[0]);
    r_sum    = {1'b0, r_sig[26:3]} + {24'b0, round_up};
    r_exp    = pr_exp + (r_sum[24] ? 10'sd1 : 10'sd0);
    r_frac   = r_sum[24] ? r_sum[23:1] : r_sum[22:0];
    if (pr_special)            rnd_res = pr_val;
    else if (r_exp >= 10'sd255) rnd_res = {pr_sign, POS_INF[30:0]};
    else if (r_exp <= 10'sd0)   rnd_res = {pr_sign, 31'b0};
    else                        rnd_res = {pr_sign, r_exp[7:0], r_frac};
  end

endmodule

// File: tb/tb_fpu_top.sv
// tb/tb_fpu_top.sv - directed-vector bench for fpu_top
module tb_fpu_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid;
  logic [31:0] din1, din2;
  logic [1:0]  op_sel;
  logic [31:0] result;
  logic        ready;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fpu_top dut (
    .clk    (clk),
    .reset  (reset),
    .valid  (valid),
    .din1   (din1),
    .din2   (din2),
    .op_sel (op_sel),
    .result (result),
    .ready  (ready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // latency = falling edges after the capture edge until ready is seen high
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    din1 = a; din2 = b; op_sel = op; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0; din1 = ~a; din2 = $urandom; op_sel = ~op;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 100);
    res = result;
  endtask

  task automatic vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] op, input logic [31:0] want, input int want_lat);
    logic [31:0] r;
    int          lat;
    run_op(a, b, op, r, lat);
    chk(tag, r, want);
    chk({tag, "_lat"}, 32'(lat), 32'(want_lat));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int pulses;
    reset = 1'b0; valid = 1'b0; din1 = '0; din2 = '0; op_sel = 2'd0;
    repeat (3) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_ready", {31'b0, ready}, 32'h0);
    reset = 1'b1;

    vec("add_1_1",    32'h3F800000, 32'h3F800000, 2'd0, 32'h40000000, 4);
    vec("add_2_3",    32'h40000000, 32'h40400000, 2'd0, 32'h40A00000, 4);
    vec("add_cancel", 32'hC0000000, 32'h40000000, 2'd0, 32'h00000000, 4);
    vec("sub_2_3",    32'h40000000, 32'h40400000, 2'd1, 32'hBF800000, 4);
    vec("sub_m2_2",   32'hC0000000, 32'h40000000, 2'd1, 32'hC0800000, 4);
    vec("sub_inf",    32'h7F800000, 32'h3F800000, 2'd1, 32'h7F800000, 4);
    vec("mul_35_175", 32'h40600000, 32'h3FE00000, 2'd2, 32'h40C40000, 4);
    vec("mul_neg",    32'h40B00000, 32'hC0000000, 2'd2, 32'hC1300000, 4);
    vec("mul_inf_0",  32'h7F800000, 32'h00000000, 2'd2, 32'h7FC00000, 4);
    vec("rne_tie_ev", 32'h3F800000, 32'h33800000, 2'd0, 32'h3F800000, 4);
    vec("rne_tie_od", 32'h3F800001, 32'h33800000, 2'd0, 32'h3F800002, 4);
    vec("mul_ovf",    32'h7F7FFFFF, 32'h40000000, 2'd2, 32'h7F800000, 4);
    vec("mul_unf",    32'h80800000, 32'h3F000000, 2'd2, 32'h80000000, 4);
    vec("mul_subn",   32'h00400000, 32'h4B000000, 2'd2, 32'h0B800000, 4);
    vec("mul_negz",   32'h80000000, 32'h3F800000, 2'd2, 32'h80000000, 4);
    vec("add_nan",    32'h7FC00001, 32'h3F800000, 2'd0, 32'h7FC00000, 4);
    vec("sub_inf_inf",32'h7F800000, 32'h7F800000, 2'd1, 32'h7FC00000, 4);
`ifdef FPU_DIV_EN
    vec("div_7_2",    32'h40E00000, 32'h40000000, 2'd3, 32'h40600000, 29);
    vec("div_1_2",    32'h3F800000, 32'h40000000, 2'd3, 32'h3F000000, 29);
    vec("div_1_3",    32'h3F800000, 32'h40400000, 2'd3, 32'h3EAAAAAB, 29);
    vec("div_by_0",   32'h00000001, 32'h00000000, 2'd3, 32'h7F800000, 29);
    vec("div_0_0",    32'h00000000, 32'h00000000, 2'd3, 32'h7FC00000, 29);
`else
    vec("div_off",    32'h40E00000, 32'h40000000, 2'd3, 32'h7FC00000, 4);
`endif

    repeat (3) @(negedge clk);
    chk("hold_result", result, 32'h7FC00000);
    chk("hold_ready", {31'b0, ready}, 32'h0);

    // valid held high while busy must neither restart nor queue a second op
    @(negedge clk);
    din1 = 32'h40400000; din2 = 32'h40000000; op_sel = 2'd2; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    @(negedge clk);
    din1 = 32'h3F800000; din2 = 32'h3F800000; op_sel = 2'd0; valid = 1'b1;
    lat = 1;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 100);
    valid = 1'b0;
    chk("busy_result", result, 32'h40C00000);
    chk("busy_lat", 32'(lat), 32'd4);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("busy_no_queue", 32'(pulses), 32'd0);

    // reset in the middle of an operation
    @(negedge clk);
    din1 = 32'h40E00000; din2 = 32'h40000000; op_sel = 2'd3; valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_result", result, 32'h0);
    chk("midrst_ready", {31'b0, ready}, 32'h0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    reset = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    chk("midrst_no_ready", 32'(pulses), 32'd0);
    vec("after_rst", 32'h40000000, 32'h40400000, 2'd0, 32'h40A00000, 4);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
